// File: rtl/axi_pkg.sv
// Shared AXI constants and the per-burst context tracked by both FSMs of the SRAM responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  size;
        logic [1:0]  burst;
        logic [3:0]  beat;
        logic        err;
    } burst_ctx_t;

    // Normalises a raw AW/AR request: clamps oversize beats, demotes illegal
    // WRAP lengths and the reserved burst type to INCR, and records the error.
    function automatic burst_ctx_t burst_start(
        input logic [31:0] addr,
        input logic [3:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        burst_ctx_t c;
        c.addr  = addr;
        c.len   = len;
        c.beat  = '0;
        c.err   = 1'b0;
        c.size  = size[1:0];
        c.burst = BURST_INCR;
        if (size[2]) begin
            c.size = 2'd3;
            c.err  = 1'b1;
        end
        case (burst)
            BURST_FIXED: c.burst = BURST_FIXED;
            BURST_INCR:  c.burst = BURST_INCR;
            BURST_WRAP: begin
                if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
                    c.burst = BURST_WRAP;
                else
                    c.burst = BURST_INCR;
            end
            default: begin
                c.burst = BURST_INCR;
                c.err   = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational beat-address stepper: next address for FIXED/INCR/WRAP and last-beat detect.
import axi_pkg::*;

module axi_burst_addr (
    input  burst_ctx_t  ctx,
    output logic [31:0] next_addr,
    output logic        last_beat
);

    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic [31:0] incr_addr;

    always_comb begin
        step      = 32'd1 << ctx.size;
        // WRAP lengths are 2^k-1, so (len << size) | (step-1) is container-1.
        wrap_mask = ({28'd0, ctx.len} << ctx.size) | (step - 32'd1);
        incr_addr = ctx.addr + step;
        case (ctx.burst)
            BURST_FIXED: next_addr = ctx.addr;
            BURST_WRAP:  next_addr = (ctx.addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
        last_beat = (ctx.beat == ctx.len);
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI slave endpoint over a 64-bit word memory; independent write and read FSMs share the array.
import axi_pkg::*;

module axi_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        asr_clk,
    input  logic        asr_rst,

    input  logic [31:0] axii_awaddr,
    input  logic [3:0]  axii_awlen,
    input  logic [2:0]  axii_awsize,
    input  logic [1:0]  axii_awburst,
    input  logic        axii_awlock,
    input  logic [3:0]  axii_awcache,
    input  logic [2:0]  axii_awprot,
    input  logic        axii_awvalid,
    output logic        axii_awready,

    input  logic [63:0] axii_wdata,
    input  logic [7:0]  axii_wstrb,
    input  logic        axii_wlast,
    input  logic        axii_wvalid,
    output logic        axii_wready,

    output logic [7:0]  axii_bid,
    output logic [1:0]  axii_bresp,
    output logic        axii_bvalid,
    input  logic        axii_bready,

    input  logic [7:0]  axii_arid,
    input  logic [31:0] axii_araddr,
    input  logic [3:0]  axii_arlen,
    input  logic [2:0]  axii_arsize,
    input  logic [1:0]  axii_arburst,
    input  logic        axii_arlock,
    input  logic [3:0]  axii_arcache,
    input  logic [2:0]  axii_arprot,
    input  logic        axii_arvalid,
    output logic        axii_arready,

    output logic [7:0]  axii_rid,
    output logic [63:0] axii_rdata,
    output logic [1:0]  axii_rresp,
    output logic        axii_rlast,
    output logic        axii_rvalid,
    input  logic        axii_rready
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    logic unused_inputs;
    assign unused_inputs = ^{axii_awlock, axii_awcache, axii_awprot,
                             axii_arlock, axii_arcache, axii_arprot};

    logic [63:0] mem_q [DEPTH];

    // ---------------- write path ----------------
    wstate_t    wstate_q, wstate_d;
    burst_ctx_t wctx_q, wctx_d;
    logic [1:0] bresp_q, bresp_d;
    logic [31:0] w_next_addr;
    logic        w_last_beat;
    logic        w_in_range;
    logic        w_err;
    logic        mem_we;
    logic [IDX_W-1:0] mem_widx;

    axi_burst_addr u_waddr (
        .ctx       (wctx_q),
        .next_addr (w_next_addr),
        .last_beat (w_last_beat)
    );

    assign w_in_range = in_range(wctx_q.addr);
    assign mem_widx   = word_idx(wctx_q.addr);

    always_comb begin
        wstate_d = wstate_q;
        wctx_d   = wctx_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        w_err    = wctx_q.err | ~w_in_range | (axii_wlast != w_last_beat);
        case (wstate_q)
            W_IDLE: begin
                if (axii_awvalid) begin
                    wctx_d   = burst_start(axii_awaddr, axii_awlen, axii_awsize, axii_awburst);
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axii_wvalid) begin
                    mem_we = w_in_range;
                    // Burst length comes from awlen; wlast only feeds the error flag.
                    if (w_last_beat) begin
                        bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end else begin
                        wctx_d.addr = w_next_addr;
                        wctx_d.beat = wctx_q.beat + 4'd1;
                        wctx_d.err  = w_err;
                    end
                end
            end
            W_RESP: begin
                if (axii_bready)
                    wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge asr_clk) begin
        if (asr_rst) begin
            wstate_q <= W_IDLE;
            wctx_q   <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            wctx_q   <= wctx_d;
            bresp_q  <= bresp_d;
        end
    end

    always_ff @(posedge asr_clk) begin
        if (mem_we && !asr_rst) begin
            for (int i = 0; i < 8; i++) begin
                if (axii_wstrb[i])
                    mem_q[mem_widx][i*8 +: 8] <= axii_wdata[i*8 +: 8];
            end
        end
    end

    assign axii_awready = (wstate_q == W_IDLE);
    assign axii_wready  = (wstate_q == W_DATA);
    assign axii_bvalid  = (wstate_q == W_RESP);
    assign axii_bresp   = bresp_q;
    assign axii_bid     = 8'h00;

    // ---------------- read path ----------------
    rstate_t    rstate_q, rstate_d;
    burst_ctx_t rctx_q, rctx_d;
    logic [7:0]  rid_q, rid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] r_next_addr;
    logic        r_last_beat;
    logic [31:0] rd_addr;
    logic        rd_ok;
    logic [63:0] rd_word;

    axi_burst_addr u_raddr (
        .ctx       (rctx_q),
        .next_addr (r_next_addr),
        .last_beat (r_last_beat)
    );

    // The data register is always loaded with the beat about to be presented.
    assign rd_addr = (rstate_q == R_IDLE) ? axii_araddr : r_next_addr;
    assign rd_ok   = in_range(rd_addr);
    assign rd_word = mem_q[word_idx(rd_addr)];

    always_comb begin
        rstate_d = rstate_q;
        rctx_d   = rctx_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;
        case (rstate_q)
            R_IDLE: begin
                if (axii_arvalid) begin
                    rctx_d   = burst_start(axii_araddr, axii_arlen, axii_arsize, axii_arburst);
                    rid_d    = axii_arid;
                    rdata_d  = rd_ok ? rd_word : 64'd0;
                    rresp_d  = (rctx_d.err | ~rd_ok) ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = (axii_arlen == 4'd0);
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axii_rready) begin
                    if (r_last_beat) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        rctx_d.addr = r_next_addr;
                        rctx_d.beat = rctx_q.beat + 4'd1;
                        rdata_d     = rd_ok ? rd_word : 64'd0;
                        rresp_d     = (rctx_q.err | ~rd_ok) ? RESP_SLVERR : RESP_OKAY;
                        rlast_d     = ((rctx_q.beat + 4'd1) == rctx_q.len);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge asr_clk) begin
        if (asr_rst) begin
            rstate_q <= R_IDLE;
            rctx_q   <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rctx_q   <= rctx_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign axii_arready = (rstate_q == R_IDLE);
    assign axii_rvalid  = rvalid_q;
    assign axii_rid     = rid_q;
    assign axii_rdata   = rdata_q;
    assign axii_rresp   = rresp_q;
    assign axii_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: writes, reads, bursts, strobes, errors and reset.
module tb_axi_sram_responder;

    logic        asr_clk = 1'b0;
    logic        asr_rst = 1'b1;
    logic [31:0] axii_awaddr = '0;
    logic [3:0]  axii_awlen = '0;
    logic [2:0]  axii_awsize = '0;
    logic [1:0]  axii_awburst = '0;
    logic        axii_awlock = 1'b0;
    logic [3:0]  axii_awcache = '0;
    logic [2:0]  axii_awprot = '0;
    logic        axii_awvalid = 1'b0;
    logic        axii_awready;
    logic [63:0] axii_wdata = '0;
    logic [7:0]  axii_wstrb = '0;
    logic        axii_wlast = 1'b0;
    logic        axii_wvalid = 1'b0;
    logic        axii_wready;
    logic [7:0]  axii_bid;
    logic [1:0]  axii_bresp;
    logic        axii_bvalid;
    logic        axii_bready = 1'b0;
    logic [7:0]  axii_arid = '0;
    logic [31:0] axii_araddr = '0;
    logic [3:0]  axii_arlen = '0;
    logic [2:0]  axii_arsize = '0;
    logic [1:0]  axii_arburst = '0;
    logic        axii_arlock = 1'b0;
    logic [3:0]  axii_arcache = '0;
    logic [2:0]  axii_arprot = '0;
    logic        axii_arvalid = 1'b0;
    logic        axii_arready;
    logic [7:0]  axii_rid;
    logic [63:0] axii_rdata;
    logic [1:0]  axii_rresp;
    logic        axii_rlast;
    logic        axii_rvalid;
    logic        axii_rready = 1'b0;

    axi_sram_responder dut (
        .asr_clk(asr_clk), .asr_rst(asr_rst),
        .axii_awaddr(axii_awaddr), .axii_awlen(axii_awlen), .axii_awsize(axii_awsize),
        .axii_awburst(axii_awburst), .axii_awlock(axii_awlock), .axii_awcache(axii_awcache),
        .axii_awprot(axii_awprot), .axii_awvalid(axii_awvalid), .axii_awready(axii_awready),
        .axii_wdata(axii_wdata), .axii_wstrb(axii_wstrb), .axii_wlast(axii_wlast),
        .axii_wvalid(axii_wvalid), .axii_wready(axii_wready),
        .axii_bid(axii_bid), .axii_bresp(axii_bresp), .axii_bvalid(axii_bvalid),
        .axii_bready(axii_bready),
        .axii_arid(axii_arid), .axii_araddr(axii_araddr), .axii_arlen(axii_arlen),
        .axii_arsize(axii_arsize), .axii_arburst(axii_arburst), .axii_arlock(axii_arlock),
        .axii_arcache(axii_arcache), .axii_arprot(axii_arprot), .axii_arvalid(axii_arvalid),
        .axii_arready(axii_arready),
        .axii_rid(axii_rid), .axii_rdata(axii_rdata), .axii_rresp(axii_rresp),
        .axii_rlast(axii_rlast), .axii_rvalid(axii_rvalid), .axii_rready(axii_rready)
    );

    always #5 asr_clk = ~asr_clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] wb_data [16];
    logic [7:0]  wb_strb [16];
    logic        wb_last [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [7:0]  rd_id   [16];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge asr_clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [63:0] d, input logic [7:0] s, input logic l);
        wb_data[i] = d;
        wb_strb[i] = s;
        wb_last[i] = l;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                               input logic [1:0] burst, output logic [1:0] resp);
        int t;
        axii_awaddr = addr; axii_awlen = len; axii_awsize = size; axii_awburst = burst;
        axii_awvalid = 1'b1;
        t = 0;
        while (!axii_awready && t < 20) begin step(); t++; end
        check("aw_wait", 128'(axii_awready), 128'(1));
        step();
        axii_awvalid = 1'b0;
        check("wready_after_aw", 128'(axii_wready), 128'(1));
        for (int i = 0; i <= int'(len); i++) begin
            axii_wdata = wb_data[i]; axii_wstrb = wb_strb[i]; axii_wlast = wb_last[i];
            axii_wvalid = 1'b1;
            t = 0;
            while (!axii_wready && t < 20) begin step(); t++; end
            if (!axii_wready) check("w_wait", 128'(axii_wready), 128'(1));
            step();
        end
        axii_wvalid = 1'b0;
        axii_wlast  = 1'b0;
        check("bvalid_after_last", 128'(axii_bvalid), 128'(1));
        check("bid", 128'(axii_bid), 128'(0));
        resp = axii_bresp;
        axii_bready = 1'b1;
        step();
        axii_bready = 1'b0;
        check("awready_after_b", 128'(axii_awready), 128'(1));
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [7:0] id);
        int t;
        axii_araddr = addr; axii_arlen = len; axii_arsize = 3'd3; axii_arburst = burst;
        axii_arid = id; axii_arvalid = 1'b1;
        t = 0;
        while (!axii_arready && t < 20) begin step(); t++; end
        check("ar_wait", 128'(axii_arready), 128'(1));
        step();
        axii_arvalid = 1'b0;
        check("rvalid_after_ar", 128'(axii_rvalid), 128'(1));
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                              input logic [7:0] id, input bit stall);
        int t;
        logic [74:0] snap;
        ar_issue(addr, len, burst, id);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!axii_rvalid && t < 20) begin step(); t++; end
            if (!axii_rvalid) check("r_wait", 128'(axii_rvalid), 128'(1));
            if (stall && (i % 2 == 1)) begin
                axii_rready = 1'b0;
                snap = {axii_rdata, axii_rresp, axii_rlast, axii_rid};
                step();
                check("r_stall_stable", 128'({axii_rvalid, axii_rdata, axii_rresp, axii_rlast, axii_rid}),
                      128'({1'b1, snap}));
            end
            axii_rready = 1'b1;
            rd_data[i] = axii_rdata; rd_resp[i] = axii_rresp;
            rd_last[i] = axii_rlast; rd_id[i]   = axii_rid;
            step();
            axii_rready = 1'b0;
        end
        check("arready_after_rlast", 128'(axii_arready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;

        // Reset values
        repeat (3) @(posedge asr_clk);
        #1;
        check("rst_awready", 128'(axii_awready), 128'(1));
        check("rst_arready", 128'(axii_arready), 128'(1));
        check("rst_wready",  128'(axii_wready),  128'(0));
        check("rst_bvalid",  128'(axii_bvalid),  128'(0));
        check("rst_rvalid",  128'(axii_rvalid),  128'(0));
        check("rst_rlast",   128'(axii_rlast),   128'(0));
        check("rst_bresp",   128'(axii_bresp),   128'(0));
        check("rst_rresp",   128'(axii_rresp),   128'(0));
        check("rst_rid",     128'(axii_rid),     128'(0));
        check("rst_rdata",   128'(axii_rdata),   128'(0));
        check("rst_bid",     128'(axii_bid),     128'(0));
        asr_rst = 1'b0;
        step();

        // Single write then read
        set_beat(0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
        write_burst(32'h10, 4'd0, 3'd3, 2'b01, resp);
        check("single_bresp", 128'(resp), 128'(0));
        read_burst(32'h10, 4'd0, 2'b01, 8'h5A, 1'b0);
        check("single_rdata", 128'(rd_data[0]), 128'(64'hDEADBEEF_CAFEF00D));
        check("single_rid",   128'(rd_id[0]),   128'(8'h5A));
        check("single_rlast", 128'(rd_last[0]), 128'(1));
        check("single_rresp", 128'(rd_resp[0]), 128'(0));
        $display("txn single write/read done");

        // INCR burst, read back under backpressure
        for (int i = 0; i < 4; i++) set_beat(i, 64'(i + 1), 8'hFF, i == 3);
        write_burst(32'h100, 4'd3, 3'd3, 2'b01, resp);
        check("incr_bresp", 128'(resp), 128'(0));
        read_burst(32'h100, 4'd3, 2'b01, 8'h11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), 128'(rd_data[i]), 128'(i + 1));
            check($sformatf("incr_rlast%0d", i), 128'(rd_last[i]), 128'(i == 3));
        end
        $display("txn incr burst with backpressure done");

        // WRAP burst starting at 0x38 inside 0x20..0x3F
        for (int i = 0; i < 4; i++) set_beat(i, 64'hA0 + 64'(i), 8'hFF, i == 3);
        write_burst(32'h38, 4'd3, 3'd3, 2'b10, resp);
        check("wrap_bresp", 128'(resp), 128'(0));
        read_burst(32'h20, 4'd3, 2'b01, 8'h22, 1'b0);
        check("wrap_0x20", 128'(rd_data[0]), 128'(64'hA1));
        check("wrap_0x28", 128'(rd_data[1]), 128'(64'hA2));
        check("wrap_0x30", 128'(rd_data[2]), 128'(64'hA3));
        check("wrap_0x38", 128'(rd_data[3]), 128'(64'hA0));
        $display("txn wrap burst done");

        // Partial strobes
        set_beat(0, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1);
        write_burst(32'h200, 4'd0, 3'd3, 2'b01, resp);
        set_beat(0, 64'h11223344_55667788, 8'h0F, 1'b1);
        write_burst(32'h200, 4'd0, 3'd3, 2'b01, resp);
        check("strb_bresp", 128'(resp), 128'(0));
        read_burst(32'h200, 4'd0, 2'b01, 8'h33, 1'b0);
        check("strb_rdata", 128'(rd_data[0]), 128'(64'hFFFFFFFF_55667788));
        $display("txn partial strobe done");

        // Out-of-range write must not alias onto word 0
        set_beat(0, 64'h01234567_89ABCDEF, 8'hFF, 1'b1);
        write_burst(32'h0, 4'd0, 3'd3, 2'b01, resp);
        set_beat(0, 64'h0000_0000_0000_1234, 8'hFF, 1'b1);
        write_burst(32'h2000, 4'd0, 3'd3, 2'b01, resp);
        check("oor_w_bresp", 128'(resp), 128'(2'b10));
        read_burst(32'h0, 4'd0, 2'b01, 8'h44, 1'b0);
        check("oor_w_unchanged", 128'(rd_data[0]), 128'(64'h01234567_89ABCDEF));
        $display("txn out-of-range write done");

        // Early wlast on beat 1 of a 3-beat burst
        set_beat(0, 64'h1, 8'hFF, 1'b0);
        set_beat(1, 64'h2, 8'hFF, 1'b1);
        set_beat(2, 64'h3, 8'hFF, 1'b1);
        write_burst(32'h300, 4'd2, 3'd3, 2'b01, resp);
        check("early_wlast_bresp", 128'(resp), 128'(2'b10));
        $display("txn early wlast done");

        // Out-of-range read
        read_burst(32'h2000, 4'd0, 2'b01, 8'h03, 1'b0);
        check("oor_r_rdata", 128'(rd_data[0]), 128'(0));
        check("oor_r_rresp", 128'(rd_resp[0]), 128'(2'b10));
        check("oor_r_rlast", 128'(rd_last[0]), 128'(1));
        $display("txn out-of-range read done");

        // Reset in the middle of an 8-beat read
        ar_issue(32'h100, 4'd7, 2'b01, 8'h77);
        axii_rready = 1'b1;
        step();
        check("rst_mid_beat1", 128'(axii_rdata), 128'(2));
        step();
        axii_rready = 1'b0;
        asr_rst = 1'b1;
        step();
        check("rst_mid_rvalid",  128'(axii_rvalid),  128'(0));
        check("rst_mid_arready", 128'(axii_arready), 128'(1));
        check("rst_mid_rlast",   128'(axii_rlast),   128'(0));
        asr_rst = 1'b0;
        step();
        read_burst(32'h10, 4'd0, 2'b01, 8'h66, 1'b0);
        check("post_rst_rdata", 128'(rd_data[0]), 128'(64'hDEADBEEF_CAFEF00D));
        check("post_rst_rid",   128'(rd_id[0]),   128'(8'h66));
        $display("txn reset mid-read done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
